// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package disp_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CAPT   = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t BLANK_CODE = 4'hF;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Channel inputs, shared separator link and display drive of the scan controller.
interface disp_scan_ctrl_if #(
  parameter int NUM_CH = 3
);
  logic [6*NUM_CH-1:0] CH_DATA;
  logic                FREEZE;
  logic                BLANK_LEAD;
  logic [5:0]          SEP_DATA;
  logic [3:0]          SEP_TENS;
  logic [3:0]          SEP_ONES;
  logic [2*NUM_CH-1:0] DIGIT_SEL;
  logic [3:0]          DIGIT_BCD;
  logic                DP;

  modport master (
    input  CH_DATA, FREEZE, BLANK_LEAD, SEP_TENS, SEP_ONES,
    output SEP_DATA, DIGIT_SEL, DIGIT_BCD, DP
  );

  modport slave (
    output CH_DATA, FREEZE, BLANK_LEAD, SEP_TENS, SEP_ONES,
    input  SEP_DATA, DIGIT_SEL, DIGIT_BCD, DP
  );
endinterface

// File: rtl/disp_scan_ctrl_scan_tick.sv
// Refresh divider plus digit index counter; adv pulses on the divider terminal count.
module scan_tick #(
  parameter int NUM_DIG  = 6,
  parameter int SCAN_DIV = 50000,
  parameter int IDX_W    = $clog2(NUM_DIG)
) (
  input  logic             CLK,
  input  logic             RST_N,
  output logic [IDX_W-1:0] idx,
  output logic             adv
);
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt;

  assign adv = (cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      idx <= '0;
    end else if (adv) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIG - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// Shares one tens/ones separator among NUM_CH channels, double-buffers the digits
// and scans the common-anode digit selects.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic             CLK,
  input  logic             RST_N,
  disp_scan_ctrl_if.master bus
);
  localparam int NUM_DIG = 2 * NUM_CH;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W   = $clog2(NUM_DIG);

  conv_state_t      state;
  logic [CH_W-1:0]  ch;
  logic [5:0]       sep_q;
  logic [5:0]       ch_value;
  digit_t           shadow [NUM_DIG];
  digit_t           buffer [NUM_DIG];

  logic [IDX_W-1:0]   idx;
  logic               adv;
  logic               adv_q;
  logic [NUM_DIG-1:0] sel_q;
  digit_t             bcd_q;
  logic               dp_q;

  always_comb begin
    ch_value = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch == CH_W'(k)) ch_value = bus.CH_DATA[6*k +: 6];
  end

  // Conversion pass: LOAD drives the separator, CAPT latches its result one cycle later
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= LOAD;
      ch    <= '0;
      sep_q <= '0;
      for (int i = 0; i < NUM_DIG; i++) begin
        shadow[i] <= '0;
        buffer[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          sep_q <= ch_value;
          state <= CAPT;
        end
        CAPT: begin
          for (int k = 0; k < NUM_CH; k++)
            if (ch == CH_W'(k)) begin
              shadow[2*k]   <= bus.SEP_TENS;
              shadow[2*k+1] <= bus.SEP_ONES;
            end
          if (ch == CH_W'(NUM_CH - 1)) begin
            state <= COMMIT;
          end else begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end
        end
        COMMIT: begin
          if (!bus.FREEZE) buffer <= shadow;
          ch    <= '0;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  scan_tick #(
    .NUM_DIG  (NUM_DIG),
    .SCAN_DIV (SCAN_DIV),
    .IDX_W    (IDX_W)
  ) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .idx   (idx),
    .adv   (adv)
  );

  // Display stage: select/DP move one cycle after the index; BCD re-reads the buffer every cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      adv_q <= 1'b0;
      sel_q <= {{(NUM_DIG-1){1'b1}}, 1'b0};
      bcd_q <= '0;
      dp_q  <= 1'b1;
    end else begin
      adv_q <= adv;
      bcd_q <= buffer[idx];
      if (adv_q) begin
        sel_q <= ~(NUM_DIG'(1) << idx);
        dp_q  <= ~(idx[0] & (idx != IDX_W'(NUM_DIG - 1)));
      end
    end
  end

  assign bus.SEP_DATA  = sep_q;
  assign bus.DIGIT_SEL = sel_q;
  assign bus.DP        = dp_q;
  assign bus.DIGIT_BCD = (bus.BLANK_LEAD && !sel_q[0] && bcd_q == '0) ? BLANK_CODE : bcd_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with a behavioural tens/ones separator, SCAN_DIV = 4.
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int NUM_CH   = 3;
  localparam int SCAN_DIV = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  disp_scan_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

  disp_scan_ctrl #(
    .NUM_CH   (NUM_CH),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  assign bus.SEP_TENS = 4'(bus.SEP_DATA / 6'd10);
  assign bus.SEP_ONES = 4'(bus.SEP_DATA % 6'd10);

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [31:0] bufd(input int i);
    return 32'(dut.buffer[i]);
  endfunction

  task automatic wait_sel(input logic [5:0] s, input string tag);
    for (int i = 0; i < 40 && bus.DIGIT_SEL !== s; i++) tick();
    chk(tag, 32'(bus.DIGIT_SEL), 32'(s));
  endtask

  task automatic chk_buf(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3,
                         input logic [3:0] d4, input logic [3:0] d5);
    chk({tag, "_d0"}, bufd(0), 32'(d0));
    chk({tag, "_d1"}, bufd(1), 32'(d1));
    chk({tag, "_d2"}, bufd(2), 32'(d2));
    chk({tag, "_d3"}, bufd(3), 32'(d3));
    chk({tag, "_d4"}, bufd(4), 32'(d4));
    chk({tag, "_d5"}, bufd(5), 32'(d5));
  endtask

  logic [5:0] sel_tab [6];
  logic       dp_tab  [6];
  logic [3:0] bcd_tab [6];
  logic       mixed;

  initial begin
    sel_tab = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
    dp_tab  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bcd_tab = '{4'd2, 4'd3, 4'd0, 4'd7, 4'd5, 4'd9};

    bus.CH_DATA    = {6'd59, 6'd7, 6'd23};
    bus.FREEZE     = 1'b0;
    bus.BLANK_LEAD = 1'b0;
    ticks(2);

    // Reset state
    chk("rst_sel", 32'(bus.DIGIT_SEL), 32'(6'b111110));
    chk("rst_bcd", 32'(bus.DIGIT_BCD), 32'd0);
    chk("rst_dp",  32'(bus.DP), 32'd1);
    chk("rst_sep", 32'(bus.SEP_DATA), 32'd0);
    bus.BLANK_LEAD = 1'b1;
    #1;
    chk("rst_bcd_blank", 32'(bus.DIGIT_BCD), 32'hF);
    bus.BLANK_LEAD = 1'b0;
    #1;

    // Scenario 1: first pass and scan walk
    RST_N = 1'b1;
    tick();
    chk("s1_sep_c1", 32'(bus.SEP_DATA), 32'd23);
    ticks(5);
    chk_buf("s1_c6", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    chk_buf("s1_c7", 4'd2, 4'd3, 4'd0, 4'd7, 4'd5, 4'd9);
    tick();
    chk("s1_sel_1", 32'(bus.DIGIT_SEL), 32'(sel_tab[1]));
    chk("s1_dp_1",  32'(bus.DP), 32'(dp_tab[1]));
    chk("s1_bcd_1", 32'(bus.DIGIT_BCD), 32'(bcd_tab[1]));
    for (int k = 2; k < 6; k++) begin
      ticks(4);
      chk($sformatf("s1_sel_%0d", k), 32'(bus.DIGIT_SEL), 32'(sel_tab[k]));
      chk($sformatf("s1_dp_%0d", k),  32'(bus.DP), 32'(dp_tab[k]));
      chk($sformatf("s1_bcd_%0d", k), 32'(bus.DIGIT_BCD), 32'(bcd_tab[k]));
    end
    tick();
    chk("s1_sel_wrap", 32'(bus.DIGIT_SEL), 32'(sel_tab[0]));
    chk("s1_dp_wrap",  32'(bus.DP), 32'(dp_tab[0]));
    chk("s1_bcd_wrap", 32'(bus.DIGIT_BCD), 32'(bcd_tab[0]));

    // Scenario 2: channel 2 steps 59 -> 0
    bus.CH_DATA = {6'd0, 6'd7, 6'd23};
    mixed = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (!((bufd(4) == 32'd5 && bufd(5) == 32'd9) || (bufd(4) == 32'd0 && bufd(5) == 32'd0)))
        mixed = 1'b1;
    end
    chk("s2_no_tear", 32'(mixed), 32'd0);
    chk("s2_d4", bufd(4), 32'd0);
    chk("s2_d5", bufd(5), 32'd0);

    // Scenario 3: freeze holds the buffer
    bus.FREEZE  = 1'b1;
    bus.CH_DATA = {6'd41, 6'd18, 6'd36};
    ticks(30);
    chk_buf("s3_frozen", 4'd2, 4'd3, 4'd0, 4'd7, 4'd0, 4'd0);
    bus.FREEZE = 1'b0;
    for (int i = 0; i < 8 && bufd(0) != 32'd3; i++) tick();
    chk_buf("s3_thaw", 4'd3, 4'd6, 4'd1, 4'd8, 4'd4, 4'd1);

    // Scenario 4: leading-zero blanking
    bus.BLANK_LEAD = 1'b1;
    bus.CH_DATA    = {6'd41, 6'd18, 6'd5};
    ticks(14);
    wait_sel(6'b111110, "s4_wait_d0");
    ticks(2);
    chk("s4_blank", 32'(bus.DIGIT_BCD), 32'hF);
    wait_sel(6'b111101, "s4_wait_d1");
    tick();
    chk("s4_ones", 32'(bus.DIGIT_BCD), 32'd5);
    bus.CH_DATA = {6'd41, 6'd18, 6'd15};
    ticks(14);
    wait_sel(6'b111110, "s4_wait_d0b");
    ticks(2);
    chk("s4_noblank", 32'(bus.DIGIT_BCD), 32'd1);

    // Scenario 5: 63 is not clamped
    bus.BLANK_LEAD = 1'b0;
    bus.CH_DATA    = {6'd41, 6'd63, 6'd15};
    ticks(14);
    wait_sel(6'b111011, "s5_wait_d2");
    tick();
    chk("s5_tens", 32'(bus.DIGIT_BCD), 32'd6);
    wait_sel(6'b110111, "s5_wait_d3");
    tick();
    chk("s5_ones", 32'(bus.DIGIT_BCD), 32'd3);
    chk("s5_dp",   32'(bus.DP), 32'd0);

    // Scenario 6: reset during CAPT of channel 1
    for (int i = 0; i < 10 && !(dut.state == CAPT && dut.ch == 1); i++) tick();
    chk("s6_reach_capt", 32'(dut.state), 32'(CAPT));
    RST_N = 1'b0;
    #1;
    chk("s6_sel", 32'(bus.DIGIT_SEL), 32'(6'b111110));
    chk("s6_bcd", 32'(bus.DIGIT_BCD), 32'd0);
    chk("s6_dp",  32'(bus.DP), 32'd1);
    chk("s6_sep", 32'(bus.SEP_DATA), 32'd0);
    chk("s6_state", 32'(dut.state), 32'(LOAD));
    chk_buf("s6_rst", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    RST_N = 1'b1;
    ticks(6);
    chk("s6_c6_d2", bufd(2), 32'd0);
    tick();
    chk_buf("s6_c7", 4'd1, 4'd5, 4'd6, 4'd3, 4'd4, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
